// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: one core request becomes a single bus cycle of
// 1..MAX_BURST word beats on incrementing addresses, with retry, error and timeout handling.
module wb_burst_master #(
  parameter int MAX_BURST   = 8,
  parameter int RETRY_LIMIT = 3,
  parameter int TIMEOUT     = 255,
  parameter int TAGSIZE     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_i,
  input  logic                           we_i,
  input  logic [31:0]                    addr_i,
  input  logic [3:0]                     sel_i,
  input  logic [$clog2(MAX_BURST):0]     len_i,
  input  logic [31:0]                    wdata_i,
  output logic                           wdata_ack_o,
  output logic [31:0]                    rdata_o,
  output logic                           rdata_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [31:0]                    wb_adr_o,
  output logic [31:0]                    wb_dat_o,
  output logic [3:0]                     wb_sel_o,
  output logic                           wb_we_o,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic [TAGSIZE-1:0]             wb_tga_o,
  output logic [TAGSIZE-1:0]             wb_tgd_o,
  output logic [TAGSIZE-1:0]             wb_tgc_o,
  input  logic [31:0]                    wb_dat_i,
  input  logic                           wb_ack_i,
  input  logic                           wb_err_i,
  input  logic                           wb_rty_i,
  input  logic [TAGSIZE-1:0]             wb_tgd_i
);
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RETRY} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] beat_q, beat_d, len_q, len_d, len_clamped;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   adr_q, adr_d, rdata_q, rdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          done_q, done_d, err_q, err_d, rvalid_q, rvalid_d;
  logic          unused_tgd;

  assign unused_tgd = ^wb_tgd_i;

  always_comb begin
    len_clamped = len_i;
    if (len_i == '0) len_clamped = LW'(1);
    else if (len_i > LW'(MAX_BURST)) len_clamped = LW'(MAX_BURST);
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = BUS;
          we_d    = we_i;
          adr_d   = {addr_i[31:2], 2'b00};
          sel_d   = sel_i;
          len_d   = len_clamped;
          beat_d  = '0;
          retry_d = '0;
          tmo_d   = '0;
        end
      end
      BUS: begin
        // Response priority: err > ack > rty > timeout.
        if (wb_err_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wb_ack_i) begin
          if (!we_q) begin
            rdata_d  = wb_dat_i;
            rvalid_d = 1'b1;
          end
          beat_d  = beat_q + LW'(1);
          retry_d = '0;
          tmo_d   = '0;
          if (beat_q == len_q - LW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            adr_d = adr_q + 32'd4;
          end
        end else if (wb_rty_i) begin
          if (retry_q == RW'(RETRY_LIMIT)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            retry_d = retry_q + RW'(1);
            tmo_d   = '0;
            state_d = RETRY;
          end
        end else if (TIMEOUT != 0 && tmo_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RETRY: state_d = BUS;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      len_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Core write stream: wdata_i is the head word, wdata_ack_o pops it on an accepted (non-err) write beat.
  assign wdata_ack_o   = wb_ack_i & ~wb_err_i & wb_cyc_o & wb_stb_o & we_q;
  assign wb_dat_o      = (state_q == BUS && we_q) ? wdata_i : 32'd0;
  assign wb_cyc_o      = (state_q != IDLE);
  assign wb_stb_o      = (state_q == BUS);
  assign wb_adr_o      = adr_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_tga_o      = '0;
  assign wb_tgd_o      = '0;
  assign wb_tgc_o      = '0;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: scripted/random slave responses, checked cycle by cycle
// against a transaction-level reference model of the burst rules.
module tb_wb_burst_master;
  localparam int MAXB = 8;
  localparam int RL   = 3;
  localparam int TMO  = 5;
  localparam int TS   = 2;
  localparam int LW   = $clog2(MAXB) + 1;
  localparam int R_NONE = 0, R_ACK = 1, R_RTY = 2, R_ERR = 3, R_ACKERR = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, we_i;
  logic [31:0]   addr_i, wdata_i;
  logic [3:0]    sel_i;
  logic [LW-1:0] len_i;
  logic          wdata_ack_o, rdata_valid_o, busy_o, done_o, err_o;
  logic [31:0]   rdata_o, wb_adr_o, wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [TS-1:0] wb_tga_o, wb_tgd_o, wb_tgc_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_rty_i;

  wb_burst_master #(.MAX_BURST(MAXB), .RETRY_LIMIT(RL), .TIMEOUT(TMO), .TAGSIZE(TS)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .len_i(len_i), .wdata_i(wdata_i), .wdata_ack_o(wdata_ack_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_tga_o(wb_tga_o), .wb_tgd_o(wb_tgd_o), .wb_tgc_o(wb_tgc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_tgd_i('0)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  int          script_q[$];
  logic        exp_stb_q[$];
  logic [31:0] exp_adr_q[$];
  int          exp_beat_q[$];
  int          exp_resp_q[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_abort;
  logic [31:0] salt;
  logic [31:0] wstream[MAXB];
  int          rv_seen, rv_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: walk the slave script through the burst rules, one bus cycle at a time.
  task automatic build_model(input logic we, input logic [31:0] addr, input int len);
    int n, beat, retries, waitc, k, resp;
    logic [31:0] base, a;
    bit fin;
    n = (len == 0) ? 1 : ((len > MAXB) ? MAXB : len);
    base = {addr[31:2], 2'b00};
    exp_stb_q.delete(); exp_adr_q.delete(); exp_beat_q.delete();
    exp_resp_q.delete(); exp_rd_q.delete();
    exp_abort = 1'b0; beat = 0; retries = 0; waitc = 0; k = 0; fin = 1'b0;
    while (!fin) begin
      resp = (k < script_q.size()) ? script_q[k] : R_ACK;
      k++;
      a = base + 32'(4 * beat);
      exp_stb_q.push_back(1'b1); exp_adr_q.push_back(a);
      exp_beat_q.push_back(beat); exp_resp_q.push_back(resp);
      if (resp == R_ERR || resp == R_ACKERR) begin
        exp_abort = 1'b1; fin = 1'b1;
      end else if (resp == R_ACK) begin
        if (!we) exp_rd_q.push_back(a ^ salt);
        beat++; retries = 0; waitc = 0;
        if (beat == n) fin = 1'b1;
      end else if (resp == R_RTY) begin
        if (retries == RL) begin
          exp_abort = 1'b1; fin = 1'b1;
        end else begin
          retries++; waitc = 0;
          exp_stb_q.push_back(1'b0); exp_adr_q.push_back(a);
          exp_beat_q.push_back(beat); exp_resp_q.push_back(R_NONE);
        end
      end else begin
        if (waitc == TMO) begin
          exp_abort = 1'b1; fin = 1'b1;
        end else waitc++;
      end
    end
    rv_exp = exp_rd_q.size();
  endtask

  task automatic sample_rv();
    if (rdata_valid_o) begin
      rv_seen++;
      if (exp_rd_q.size() > 0) check("rdata", rdata_o, exp_rd_q.pop_front());
      else check("rv_extra", rdata_valid_o, 1'b0);
    end
  endtask

  task automatic drive_resp(input int r, input logic [31:0] data);
    wb_ack_i = (r == R_ACK || r == R_ACKERR);
    wb_err_i = (r == R_ERR || r == R_ACKERR);
    wb_rty_i = (r == R_RTY);
    wb_dat_i = data;
  endtask

  // Driver: one request, then cycle-by-cycle comparison against the model.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input int len, input bit noisy);
    int ncyc;
    build_model(we, addr, len);
    ncyc = exp_stb_q.size();
    rv_seen = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; len_i = LW'(len);
    wdata_i = wstream[0];
    @(negedge clk);
    req_i = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      sample_rv();
      check("busy", busy_o, 1'b1);
      check("done_early", done_o, 1'b0);
      check("cyc", wb_cyc_o, 1'b1);
      check("stb", wb_stb_o, exp_stb_q[c]);
      wdata_i = wstream[exp_beat_q[c]];
      if (exp_stb_q[c]) begin
        check("adr", wb_adr_o, exp_adr_q[c]);
        check("sel", wb_sel_o, sel);
        check("we", wb_we_o, we);
        drive_resp(exp_resp_q[c], exp_adr_q[c] ^ salt);
        #1;
        check("wb_dat", wb_dat_o, we ? wstream[exp_beat_q[c]] : 32'd0);
        check("wdata_ack", wdata_ack_o, we && exp_resp_q[c] == R_ACK);
      end else begin
        if (noisy) drive_resp($urandom_range(0, 4), $urandom);
        else drive_resp(R_NONE, 32'd0);
        #1;
        check("wdata_ack_gap", wdata_ack_o, 1'b0);
      end
      if (noisy) begin
        req_i = 1'($urandom_range(0, 1)); we_i = 1'($urandom_range(0, 1));
        addr_i = $urandom; len_i = LW'($urandom_range(0, 9));
      end
      @(negedge clk);
    end
    req_i = 1'b0;
    drive_resp(R_NONE, 32'd0);
    sample_rv();
    check("done", done_o, 1'b1);
    check("err", err_o, exp_abort);
    check("busy_end", busy_o, 1'b0);
    check("cyc_end", wb_cyc_o, 1'b0);
    check("rv_count", rv_seen, rv_exp);
    @(negedge clk);
    check("done_pulse", done_o, 1'b0);
    check("err_pulse", err_o, 1'b0);
    check("rv_pulse", rdata_valid_o, 1'b0);
    check("cyc_idle", wb_cyc_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; len_i = '0;
    wdata_i = '0; drive_resp(R_NONE, 32'd0); salt = '0;
    for (int i = 0; i < MAXB; i++) wstream[i] = $urandom;
    repeat (2) @(negedge clk);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", wb_sel_o, 4'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_flags", {done_o, err_o, rdata_valid_o, wdata_ack_o, busy_o}, 5'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Single read
    salt = 32'h1000 ^ 32'hDEADBEEF;
    script_q = '{R_ACK};
    run_txn(1'b0, 32'h1003, 4'hF, 1, 1'b0);

    // Write burst 1,2,3,4
    for (int i = 0; i < 4; i++) wstream[i] = 32'(i + 1);
    script_q = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_txn(1'b1, 32'h2000, 4'hF, 4, 1'b0);

    // Clamp and wrap
    salt = 32'h5A5A_0000;
    script_q.delete();
    run_txn(1'b0, 32'h4000, 4'h3, 0, 1'b0);
    run_txn(1'b0, 32'h5000, 4'hC, 9, 1'b0);
    run_txn(1'b0, 32'hFFFF_FFF8, 4'hF, 3, 1'b0);

    // Retry: recover, then exhaust
    script_q = '{R_ACK, R_RTY, R_RTY, R_ACK, R_ACK};
    run_txn(1'b0, 32'h6000, 4'hF, 3, 1'b0);
    script_q = '{R_RTY, R_RTY, R_RTY, R_RTY};
    run_txn(1'b1, 32'h6100, 4'hF, 2, 1'b0);

    // Err on beat 2 of 4, timeout, ack+err together
    script_q = '{R_ACK, R_ERR};
    run_txn(1'b0, 32'h7000, 4'hF, 4, 1'b0);
    script_q = '{R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE, R_NONE};
    run_txn(1'b0, 32'h7100, 4'hF, 1, 1'b0);
    script_q = '{R_ACKERR};
    run_txn(1'b0, 32'h7200, 4'hF, 2, 1'b0);

    // req_i held/toggled during a burst with noise in retry gaps
    script_q = '{R_ACK, R_RTY, R_ACK, R_ACK};
    run_txn(1'b1, 32'h8000, 4'h5, 3, 1'b1);

    // Reset mid-burst
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h9000; sel_i = 4'hF; len_i = LW'(4);
    @(negedge clk);
    req_i = 1'b0; drive_resp(R_ACK, 32'h1234_5678);
    @(negedge clk);
    drive_resp(R_ACK, 32'h1234_5679);
    #2 rst_i = 1'b1;
    #1;
    check("arst_cyc", wb_cyc_o, 1'b0);
    check("arst_stb", wb_stb_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    @(negedge clk);
    drive_resp(R_NONE, 32'd0);
    check("arst_done", done_o, 1'b0);
    check("arst_rdata", rdata_o, 32'd0);
    check("arst_adr", wb_adr_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("arst_done2", done_o, 1'b0);
    check("arst_cyc2", wb_cyc_o, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int sl;
      salt = $urandom;
      for (int i = 0; i < MAXB; i++) wstream[i] = $urandom;
      script_q.delete();
      sl = $urandom_range(0, 12);
      for (int i = 0; i < sl; i++) begin
        int p;
        p = $urandom_range(0, 99);
        if (p < 60) script_q.push_back(R_ACK);
        else if (p < 78) script_q.push_back(R_NONE);
        else if (p < 91) script_q.push_back(R_RTY);
        else if (p < 96) script_q.push_back(R_ERR);
        else script_q.push_back(R_ACKERR);
      end
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
